// File: rtl/uart_serializer_buf_pkg.sv
// Shared types and helpers for the UART TX serializer and its holding register.
package uart_serializer_buf_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } ser_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Words narrower than 32 bits are zero-extended by the caller, which leaves the XOR unchanged.
  function automatic logic calc_parity(input logic [31:0] word, input logic par_type);
    return (^word) ^ par_type;
  endfunction

endpackage

// File: rtl/uart_ser_hold_reg.sv
// One-deep valid/ready holding register; shared by the TX serializer and usable on the RX side.
module uart_ser_hold_reg
  import uart_serializer_buf_pkg::*;
#(
  parameter int unsigned Width = DATA_WIDTH_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] data_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic             drain_i,
  output logic [Width-1:0] data_o,
  output logic             full_o
);

  logic             full_q, full_d;
  logic             ready_q;
  logic [Width-1:0] data_q, data_d;
  logic             accept;

  assign accept = valid_i && ready_q;

  // Accept and drain are mutually exclusive: ready is low whenever the register is full.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (accept) begin
      full_d = 1'b1;
      data_d = data_i;
    end else if (drain_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      full_q  <= 1'b0;
      ready_q <= 1'b1;
      data_q  <= '0;
    end else begin
      full_q  <= full_d;
      ready_q <= !full_d;
      data_q  <= data_d;
    end
  end

  assign ready_o = ready_q;
  assign data_o  = data_q;
  assign full_o  = full_q;

endmodule

// File: rtl/uart_serializer_buf.sv
// UART TX shift stage with a one-deep input buffer; back-to-back words stream without gaps.
// Define UART_SER_PARITY_EN to append a parity bit (par_type selects even/odd) after each word.
module uart_serializer_buf
  import uart_serializer_buf_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter bit          MSB_FIRST  = 1'b0,
  parameter bit          IDLE_LEVEL = 1'b1
) (
  input  logic                  CLK,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  data_valid,
  output logic                  data_ready,
  input  logic                  shift_en,
  input  logic                  par_type,
  output logic                  ser_data,
  output logic                  ser_busy,
  output logic                  ser_done
);

  localparam int unsigned      CntW   = $clog2(DATA_WIDTH);
  localparam logic [CntW-1:0]  CntMax = CntW'(DATA_WIDTH - 1);

  localparam logic [1:0] S_IDLE   = IDLE;
  localparam logic [1:0] S_SHIFT  = SHIFT;
  localparam logic [1:0] S_PARITY = PARITY;

`ifdef UART_SER_PARITY_EN
  localparam int unsigned HoldW = DATA_WIDTH + 1;
`else
  localparam int unsigned HoldW = DATA_WIDTH;
`endif

  logic [HoldW-1:0]      hold_in, hold_out;
  logic                  hold_full, hold_drain;
  logic [DATA_WIDTH-1:0] hold_word;

  logic [1:0]            state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  ser_q, ser_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  load, word_end;

  // Parity is computed once at accept and travels with the word.
`ifdef UART_SER_PARITY_EN
  logic par_q, par_d;
  assign hold_in = {calc_parity(32'(P_DATA), par_type), P_DATA};
`else
  logic unused_par_type;
  assign unused_par_type = par_type;
  assign hold_in         = P_DATA;
`endif

  assign hold_word = hold_out[DATA_WIDTH-1:0];

  uart_ser_hold_reg #(
    .Width (HoldW)
  ) u_hold (
    .clk_i   (CLK),
    .rst_ni  (rst_n),
    .data_i  (hold_in),
    .valid_i (data_valid),
    .ready_o (data_ready),
    .drain_i (hold_drain),
    .data_o  (hold_out),
    .full_o  (hold_full)
  );

  function automatic logic bit_sel(input logic [DATA_WIDTH-1:0] w, input logic [CntW-1:0] i);
    return MSB_FIRST ? w[CntMax - i] : w[i];
  endfunction

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    ser_d      = ser_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    load       = 1'b0;
    word_end   = 1'b0;
`ifdef UART_SER_PARITY_EN
    par_d      = par_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (hold_full) load = 1'b1;
      end
      S_SHIFT: begin
        if (shift_en) begin
          if (cnt_q != CntMax) begin
            cnt_d = cnt_q + 1'b1;
            ser_d = bit_sel(shift_q, cnt_q + 1'b1);
          end else begin
`ifdef UART_SER_PARITY_EN
            state_d = S_PARITY;
            ser_d   = par_q;
`else
            word_end = 1'b1;
`endif
          end
        end
      end
`ifdef UART_SER_PARITY_EN
      S_PARITY: begin
        if (shift_en) word_end = 1'b1;
      end
`endif
      default: begin
        state_d = S_IDLE;
        ser_d   = IDLE_LEVEL;
        busy_d  = 1'b0;
      end
    endcase

    // A word ending with the buffer full reloads on the same edge, so the line never idles.
    if (word_end) begin
      done_d = 1'b1;
      if (hold_full) begin
        load = 1'b1;
      end else begin
        state_d = S_IDLE;
        ser_d   = IDLE_LEVEL;
        busy_d  = 1'b0;
      end
    end

    if (load) begin
      state_d = S_SHIFT;
      cnt_d   = '0;
      shift_d = hold_word;
      ser_d   = bit_sel(hold_word, '0);
      busy_d  = 1'b1;
`ifdef UART_SER_PARITY_EN
      par_d   = hold_out[DATA_WIDTH];
`endif
    end
  end

  assign hold_drain = load;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      ser_q   <= IDLE_LEVEL;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      ser_q   <= ser_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef UART_SER_PARITY_EN
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end
`endif

  assign ser_data = ser_q;
  assign ser_busy = busy_q;
  assign ser_done = done_q;

endmodule

// File: tb/tb_uart_serializer_buf.sv
// Directed bench for uart_serializer_buf: LSB-first and MSB-first instances share one stimulus.
module tb_uart_serializer_buf;

  localparam int unsigned W = 8;

  logic         CLK = 1'b0;
  logic         rst_n;
  logic [W-1:0] P_DATA;
  logic         data_valid, shift_en, par_type;
  logic         rdy0, ser0, busy0, done0;
  logic         rdy1, ser1, busy1, done1;

  typedef struct packed {
    logic b;
    logic last;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   nchk  = 0;
  int   nfail = 0;

  always #5 CLK = ~CLK;

  uart_serializer_buf #(
    .DATA_WIDTH (W),
    .MSB_FIRST  (1'b0),
    .IDLE_LEVEL (1'b1)
  ) u_lsb (
    .CLK        (CLK),
    .rst_n      (rst_n),
    .P_DATA     (P_DATA),
    .data_valid (data_valid),
    .data_ready (rdy0),
    .shift_en   (shift_en),
    .par_type   (par_type),
    .ser_data   (ser0),
    .ser_busy   (busy0),
    .ser_done   (done0)
  );

  uart_serializer_buf #(
    .DATA_WIDTH (W),
    .MSB_FIRST  (1'b1),
    .IDLE_LEVEL (1'b1)
  ) u_msb (
    .CLK        (CLK),
    .rst_n      (rst_n),
    .P_DATA     (P_DATA),
    .data_valid (data_valid),
    .data_ready (rdy1),
    .shift_en   (shift_en),
    .par_type   (par_type),
    .ser_data   (ser1),
    .ser_busy   (busy1),
    .ser_done   (done1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [W-1:0] w);
    logic lastd;
    for (int i = 0; i < W; i++) begin
`ifdef UART_SER_PARITY_EN
      lastd = 1'b0;
`else
      lastd = (i == W - 1);
`endif
      q0.push_back('{b: w[i], last: lastd});
      q1.push_back('{b: w[W-1-i], last: lastd});
    end
`ifdef UART_SER_PARITY_EN
    q0.push_back('{b: (^w) ^ par_type, last: 1'b1});
    q1.push_back('{b: (^w) ^ par_type, last: 1'b1});
`endif
  endtask

  // One clock; a handshake seen before the edge is logged into the scoreboard.
  task automatic tick();
    logic acc;
    acc = data_valid && rdy0;
    @(posedge CLK);
    #1;
    if (acc) begin
      push_word(P_DATA);
      data_valid = 1'b0;
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, " ser0 idle"}, ser0, 1);
    chk({tag, " ser1 idle"}, ser1, 1);
    chk({tag, " busy idle"}, busy0, 0);
    chk({tag, " ready idle"}, rdy0, 1);
  endtask

  task automatic shift_bit(input string tag);
    exp_t e0, e1;
    if (q0.size() == 0 || q1.size() == 0) begin
      nfail++;
      $error("FAIL %s: scoreboard empty, observed ser %0b expected a pending bit", tag, ser0);
      return;
    end
    e0 = q0.pop_front();
    e1 = q1.pop_front();
    chk({tag, " lsb bit"}, ser0, e0.b);
    chk({tag, " msb bit"}, ser1, e1.b);
    chk({tag, " busy"}, busy0, 1);
    shift_en = 1'b1;
    tick();
    shift_en = 1'b0;
    chk({tag, " lsb done"}, done0, e0.last);
    chk({tag, " msb done"}, done1, e1.last);
    tick();
    chk({tag, " done one cycle"}, done0, 0);
  endtask

  task automatic send(input string tag, input logic [W-1:0] w);
    P_DATA     = w;
    data_valid = 1'b1;
    tick();
    chk({tag, " ready low after accept"}, rdy0, 0);
    chk({tag, " no bit before load"}, busy0, 0);
    tick();
    chk({tag, " ready back"}, rdy0, 1);
    chk({tag, " busy after load"}, busy1, 1);
  endtask

  task automatic drain_all(input string tag);
    while (q0.size() > 0) shift_bit(tag);
  endtask

  initial begin
    rst_n      = 1'b0;
    P_DATA     = '0;
    data_valid = 1'b0;
    shift_en   = 1'b0;
    par_type   = 1'b0;
    #12;
    chk("reset ready", rdy0, 1);
    chk("reset ser", ser0, 1);
    chk("reset busy", busy0, 0);
    chk("reset done", done0, 0);
    @(negedge CLK);
    rst_n = 1'b1;
    tick();

    // shift_en while idle must do nothing
    shift_en = 1'b1;
    tick();
    shift_en = 1'b0;
    chk("idle shift done", done0, 0);
    check_idle("idle shift");

    send("a5", 8'hA5);
    drain_all("a5");
    check_idle("a5 end");

    send("81", 8'h81);
    drain_all("81");
    check_idle("81 end");

    // Back-to-back plus a third word offered while the buffer is full
    send("0f", 8'h0F);
    P_DATA     = 8'hF0;
    data_valid = 1'b1;
    shift_bit("0f");
    chk("f0 accepted", data_valid, 0);
    chk("hold full ready", rdy0, 0);
    P_DATA     = 8'h33;
    data_valid = 1'b1;
    shift_bit("0f");
    chk("third blocked", rdy0, 0);
    P_DATA = 8'h55;
    drain_all("b2b");
    check_idle("b2b end");

    // Reset mid-word after three bits
    send("3c", 8'h3C);
    for (int i = 0; i < 3; i++) shift_bit("3c");
    rst_n = 1'b0;
    #1;
    chk("mid rst ser", ser0, 1);
    chk("mid rst busy", busy0, 0);
    chk("mid rst ready", rdy0, 1);
    chk("mid rst done", done0, 0);
    q0.delete();
    q1.delete();
    tick();
    @(negedge CLK);
    rst_n = 1'b1;
    tick();
    chk("post rst done", done0, 0);
    check_idle("post rst");
    send("c3", 8'hC3);
    drain_all("c3");
    check_idle("c3 end");

    par_type = 1'b0;
    send("07 even", 8'h07);
    drain_all("07 even");
    par_type = 1'b1;
    send("07 odd", 8'h07);
    drain_all("07 odd");
    check_idle("final");

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/uart_serializer_buf.md
Name: uart_serializer_buf

Overview:
- Parametrised successor of the TX shift stage in the UART-ALU datapath.
- Accepts parallel words through a valid/ready handshake into a one-deep holding register.
- Shifts each word out one bit per shift_en strobe (the baud tick from the TX FSM), LSB- or MSB-first.
- Back-to-back words stream with no idle gap; a one-cycle ser_done pulse marks each word's end.

Parameters:
- DATA_WIDTH, 8, word width in bits (range 2..32).
- MSB_FIRST, 0, 0 = bit 0 sent first; 1 = bit DATA_WIDTH-1 sent first.
- IDLE_LEVEL, 1, ser_data value while nothing is shifting (UART line high).

Ports:
- CLK  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- P_DATA  in  DATA_WIDTH  parallel word; sampled on handshake.
- data_valid  in  1  P_DATA is valid.
- data_ready  out  1  holding register empty; word accepted when data_valid && data_ready.
- shift_en  in  1  one-cycle bit-advance strobe.
- par_type  in  1  0 = even, 1 = odd parity; used only with the optional feature.
- ser_data  out  1  serial bit, registered.
- ser_busy  out  1  high while a word or parity bit is on ser_data.
- ser_done  out  1  one-cycle pulse after the last bit's period ends.

Behaviour:
- Reset (async, any state): FSM = IDLE; bit counter = 0; hold_full = 0.
  - Outputs on reset: data_ready = 1, ser_data = IDLE_LEVEL, ser_busy = 0, ser_done = 0.
  - Reset mid-word drops the word silently and clears the holding register.
- Handshake:
  - data_ready = !hold_full, driven from a register.
  - On accept: hold_q <= P_DATA and hold_full <= 1.
  - data_valid with data_ready low is ignored. The producer holds the word until it is accepted.
- IDLE state:
  - ser_data = IDLE_LEVEL.
  - If hold_full: shift_q <= hold_q, hold_full <= 0, counter <= 0, ser_data <= first bit, ser_busy <= 1, go to SHIFT.
  - Latency: accept edge N, then first bit on ser_data after edge N+1.
- SHIFT state:
  - ser_data holds bit index cnt (or DATA_WIDTH-1-cnt when MSB_FIRST) until shift_en.
  - shift_en with cnt < DATA_WIDTH-1: cnt++ and present the next bit.
  - shift_en with cnt == DATA_WIDTH-1: ser_done <= 1 for exactly one cycle.
    - If hold_full: reload in the same edge (cnt = 0, first bit of the new word, ser_busy stays 1, hold_full <= 0). No gap.
    - Else: go to IDLE, ser_data <= IDLE_LEVEL, ser_busy <= 0.
  - Without shift_en: all state holds. There is no timeout.
- Simultaneous events:
  - An accept and a hold drain never coincide, because data_ready is low whenever hold_full is set.
  - A new accept is allowed on the cycle after the drain.
  - shift_en while in IDLE has no effect.
- Counter width is $clog2(DATA_WIDTH). It wraps only by explicit reload, never by overflow.

Optional Feature:
- Macro: UART_SER_PARITY_EN.
- Defined:
  - A PARITY state follows the last data bit.
  - Parity bit = ^word XOR par_type, computed at load and stored with the word.
  - It is held for one shift_en period.
  - ser_done fires on the shift_en that ends the parity bit; reload and IDLE rules then apply as above.
- Undefined: par_type is ignored, the PARITY state is not built, and ser_done follows the last data bit.

Decomposition:
- UART_pkg provides:
  - DATA_WIDTH default.
  - ser_state_e enum {IDLE, SHIFT, PARITY}.
  - PAR_EVEN / PAR_ODD constants.
  - A parity function.
- One natural sub-module: uart_ser_hold_reg. It is the valid/ready holding register, reusable on the RX side.
- The FSM and shifter stay in the top module.

Test Plan:
- Reset, then send 8'hA5 (LSB-first).
  - ser_data = 1,0,1,0,0,1,0,1 across successive shift_en pulses.
  - ser_done pulses once; line returns to 1; ser_busy drops.
- Build with MSB_FIRST = 1, send 8'h81.
  - ser_data = 1,0,0,0,0,0,0,1.
  - data_ready is 0 for one cycle after accept, then 1.
- Back-to-back 8'h0F then 8'hF0, second accepted while the first is shifting.
  - 16 contiguous bits with no IDLE_LEVEL gap.
  - Two ser_done pulses 8 shift_en apart.
- Offer a third word while hold_full = 1.
  - data_ready = 0; word is not captured until the hold drains; P_DATA changes while not ready are ignored.
- Assert rst_n low mid-word (after 3 bits).
  - Immediate ser_data = 1, ser_busy = 0, data_ready = 1.
  - No ser_done; the next word starts from bit 0.
- With UART_SER_PARITY_EN, send 8'h07 with par_type = 0.
  - 8 data bits, then parity 1; ser_done only after the parity bit.
  - With par_type = 1 the parity bit is 0.
